// File: rtl/note_sequencer_pkg.sv
//------------------------------------------------------------------------------
// note_seq_pkg
// Shared types and helpers for the note sequencer: state encoding, tempo
// table and note-word width.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package note_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_PLAY = 2'd2
   } seq_state_t;

   // Beats per minute for each speed-select code.
   function automatic int bpm_of(input int idx);
      case (idx)
         0:       return 40;
         1:       return 60;
         2:       return 80;
         3:       return 100;
         4:       return 120;
         5:       return 140;
         6:       return 180;
         default: return 220;
      endcase
   endfunction

   // One bit per (string, column) pair; column 0 is the open string.
   function automatic int note_width(input int num_strings, input int num_frets);
      return num_strings * (num_frets + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/note_sequencer_if.sv
//------------------------------------------------------------------------------
// note_seq_if
// Control/data bundle between the guitar inputs, the sequencer and the
// audio/display consumers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface note_seq_if
   import note_seq_pkg::*;
#(
   parameter int NUM_STRINGS = 6,
   parameter int NUM_FRETS   = 4,
   parameter int DEPTH       = 64
);
   localparam int NW = note_width(NUM_STRINGS, NUM_FRETS);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_STRINGS-1:0] strings_i;
   logic [NUM_FRETS-1:0]   frets_i;
   logic [2:0]             speed_i;
   logic                   rec_start_i;
   logic                   play_start_i;
   logic                   stop_i;
   logic                   loop_en_i;
   logic                   beat_o;
   logic [NW-1:0]          note_out_o;
   logic                   note_valid_o;
   logic [AW-1:0]          address_o;
   logic [AW:0]            length_o;
   logic                   full_o;
   logic [1:0]             state_o;

   modport master (
      output strings_i, frets_i, speed_i, rec_start_i, play_start_i, stop_i, loop_en_i,
      input  beat_o, note_out_o, note_valid_o, address_o, length_o, full_o, state_o
   );

   modport slave (
      input  strings_i, frets_i, speed_i, rec_start_i, play_start_i, stop_i, loop_en_i,
      output beat_o, note_out_o, note_valid_o, address_o, length_o, full_o, state_o
   );

endinterface

`default_nettype wire

// File: rtl/note_sequencer_beat_timer.sv
//------------------------------------------------------------------------------
// beat_timer
// Down-counter producing a one-cycle beat tick and the capture window that
// covers the last CAPTURE_CYCLES cycles of each beat.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module beat_timer
   import note_seq_pkg::*;
#(
   parameter int CAPTURE_CYCLES = 10000,
   parameter int CLK_HZ         = 50000000,
   parameter int SIM_PERIOD     = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] speed_i,
   input  logic       restart_i,
   output logic       beat_o,
   output logic       capture_o
);

   logic [31:0] reload_tbl [8];
   logic [31:0] count_q;
   logic [31:0] count_d;

   // Reload value (period minus one) for every speed code, fixed at elaboration.
   for (genvar g = 0; g < 8; g++) begin : g_period
      localparam longint PERIOD = (SIM_PERIOD != 0) ? longint'(SIM_PERIOD)
                                : (longint'(CLK_HZ) * 60) / longint'(bpm_of(g));
      assign reload_tbl[g] = 32'(PERIOD - 1);
   end

   assign beat_o    = (count_q == 32'd0);
   assign capture_o = (count_q < 32'(CAPTURE_CYCLES));

   // Next count: reload at terminal count or on restart, so speed changes land at a reload.
   always_comb begin
      count_d = count_q - 32'd1;
      if (restart_i || beat_o) begin
         count_d = reload_tbl[speed_i];
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= reload_tbl[speed_i];
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
//------------------------------------------------------------------------------
// note_sequencer
// Records one note word per beat into an internal RAM and replays it once
// or looped at the same tempo.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int NUM_STRINGS    = 6,
   parameter int NUM_FRETS      = 4,
   parameter int DEPTH          = 64,
   parameter int CAPTURE_CYCLES = 10000,
   parameter int CLK_HZ         = 50000000,
   parameter int SIM_PERIOD     = 0
) (
   input  logic     clk,
   input  logic     reset,
   note_seq_if.slave bus
);

   localparam int NW = note_width(NUM_STRINGS, NUM_FRETS);
   localparam int AW = $clog2(DEPTH);

   seq_state_t    state_q;
   logic [AW-1:0] address_q;
   logic [AW:0]   length_q;
   logic          full_q;
   logic [NW-1:0] note_out_q;
   logic          note_valid_q;
   logic [NW-1:0] acc_q;
   logic [NW-1:0] acc_d;
   logic          done_q;
   logic [NW-1:0] q_q;
   logic [NW-1:0] ram [DEPTH];

   logic          beat;
   logic          capture;
   logic          restart;
   logic          ram_we;
   logic          is_last;
   int            col_sel;
   logic [NW-1:0] note_enc;

   // Entering REC or PLAY restarts the beat so the first beat is a full period.
   assign restart = (state_q == ST_IDLE) && !bus.stop_i &&
                    (bus.rec_start_i || (bus.play_start_i && (length_q != '0)));

   beat_timer #(
      .CAPTURE_CYCLES (CAPTURE_CYCLES),
      .CLK_HZ         (CLK_HZ),
      .SIM_PERIOD     (SIM_PERIOD)
   ) u_beat_timer (
      .clk       (clk),
      .reset     (reset),
      .speed_i   (bus.speed_i),
      .restart_i (restart),
      .beat_o    (beat),
      .capture_o (capture)
   );

   // Encode strings against the highest pressed fret (column 0 when no bar pressed).
   always_comb begin
      col_sel = 0;
      for (int f = 1; f <= NUM_FRETS; f++) begin
         if (bus.frets_i[f-1]) col_sel = f;
      end
      note_enc = '0;
      for (int c = 0; c <= NUM_FRETS; c++) begin
         for (int s = 0; s < NUM_STRINGS; s++) begin
            note_enc[c*NUM_STRINGS+s] = bus.strings_i[s] && (c == col_sel);
         end
      end
   end

   assign acc_d   = acc_q | (capture ? note_enc : '0);
   assign ram_we  = (state_q == ST_REC) && beat && !bus.stop_i;
   assign is_last = ({1'b0, address_q} == (length_q - 1'b1));

   // Note RAM: write at the recording beat, registered read every cycle.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[address_q] <= acc_d;
      end
      q_q <= ram[address_q];
   end

   // Sequencer FSM with registered outputs; stop always takes precedence.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         address_q    <= '0;
         length_q     <= '0;
         full_q       <= 1'b0;
         note_out_q   <= '0;
         note_valid_q <= 1'b0;
         acc_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         note_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!bus.stop_i) begin
                  if (bus.rec_start_i) begin
                     state_q   <= ST_REC;
                     address_q <= '0;
                     length_q  <= '0;
                     full_q    <= 1'b0;
                     acc_q     <= '0;
                  end else if (bus.play_start_i && (length_q != '0)) begin
                     state_q   <= ST_PLAY;
                     address_q <= '0;
                     done_q    <= 1'b0;
                  end
               end
            end
            ST_REC: begin
               if (bus.stop_i) begin
                  state_q <= ST_IDLE;
                  acc_q   <= '0;
               end else if (beat) begin
                  address_q <= address_q + 1'b1;
                  length_q  <= length_q + 1'b1;
                  acc_q     <= '0;
                  if (length_q == (AW+1)'(DEPTH - 1)) begin
                     full_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  acc_q <= acc_d;
               end
            end
            ST_PLAY: begin
               // The last note of a single pass is shown for one cycle before leaving.
               if (bus.stop_i || done_q) begin
                  state_q    <= ST_IDLE;
                  note_out_q <= '0;
                  done_q     <= 1'b0;
               end else if (beat) begin
                  note_out_q   <= q_q;
                  note_valid_q <= 1'b1;
                  if (is_last) begin
                     if (bus.loop_en_i) address_q <= '0;
                     else               done_q    <= 1'b1;
                  end else begin
                     address_q <= address_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.beat_o       = beat;
   assign bus.note_out_o   = note_out_q;
   assign bus.note_valid_o = note_valid_q;
   assign bus.address_o    = address_q;
   assign bus.length_o     = length_q;
   assign bus.full_o       = full_q;
   assign bus.state_o      = state_q;

endmodule

`default_nettype wire
